barrett_reduce_pipe: RTL and testbench

BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

---
 rtl/barrett_reduce_pipe.sv | 129 ++++++++++++
 tb/tb_barrett_reduce_pipe.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett reduction pipeline that computes dout_r = din_a mod Q and carries a tag.
// Optional build macro BARRETT_RANGE_CHK_EN adds an err output for operands >= Q*Q.
module barrett_reduce_pipe #(
  parameter int Q     = 3433,
  parameter int K     = 12,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*K-1:0]   din_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     dout_r,
  output logic [TAG_W-1:0] out_tag
`ifdef BARRETT_RANGE_CHK_EN
  ,
  output logic             err
`endif
);

  localparam logic [2*K:0] POW2K   = (2*K+1)'(1) << (2*K);
  localparam logic [2*K:0] Q_WIDE  = (2*K+1)'(Q);
  localparam logic [2*K:0] MU_WIDE = POW2K / Q_WIDE;
  localparam logic [K:0]   MU      = (K+1)'(MU_WIDE);
  localparam logic [K+1:0] QK      = (K+2)'(Q);
  localparam logic [K+1:0] Q2K     = (K+2)'(2*Q);

  logic             w_adv;
  logic [2*K:0]     w_p1;
  logic [K:0]       w_pHi1;
  logic [K+1:0]     w_tq2;
  logic [K+1:0]     w_r2;
  logic [K+1:0]     w_red3;
  logic [K-1:0]     w_dout3;

  logic             r_v1;
  logic [K+1:0]     r_aLo1;
  logic [K:0]       r_pHi1;
  logic [TAG_W-1:0] r_tag1;

  logic             r_v2;
  logic [K+1:0]     r_r2;
  logic [TAG_W-1:0] r_tag2;

  logic             r_v3;
  logic [K-1:0]     r_dout3;
  logic [TAG_W-1:0] r_tag3;

  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign dout_r    = r_dout3;
  assign out_tag   = r_tag3;

  // Only p >> K is ever consumed, so S1 keeps just that slice of the product.
  assign w_p1   = (2*K+1)'(din_a[2*K-1:K]) * (2*K+1)'(MU);
  assign w_pHi1 = (K+1)'(w_p1 >> K);

  // r is known to be below 3Q < 2^(K+2), so modular K+2-bit arithmetic is exact.
  assign w_tq2 = (K+2)'(r_pHi1) * QK;
  assign w_r2  = r_aLo1 - w_tq2;

  always_comb begin
    w_red3 = r_r2;
    if (r_r2 >= Q2K) begin
      w_red3 = r_r2 - Q2K;
    end else if (r_r2 >= QK) begin
      w_red3 = r_r2 - QK;
    end
  end

`ifdef BARRETT_RANGE_CHK_EN
  logic w_oor1;
  logic r_err1;
  logic r_err2;
  logic r_err3;

  localparam logic [2*K:0] QSQ = Q_WIDE * Q_WIDE;

  assign w_oor1  = ({1'b0, din_a} >= QSQ);
  assign w_dout3 = r_err2 ? '0 : K'(w_red3);
  assign err     = r_err3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err1 <= 1'b0;
      r_err2 <= 1'b0;
      r_err3 <= 1'b0;
    end else if (w_adv) begin
      r_err1 <= w_oor1;
      r_err2 <= r_err1;
      r_err3 <= r_err2;
    end
  end
`else
  assign w_dout3 = K'(w_red3);
`endif

  // Every stage, including its valid bit, moves only when the output slot can drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_aLo1  <= '0;
      r_pHi1  <= '0;
      r_tag1  <= '0;
      r_v2    <= 1'b0;
      r_r2    <= '0;
      r_tag2  <= '0;
      r_v3    <= 1'b0;
      r_dout3 <= '0;
      r_tag3  <= '0;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_aLo1  <= din_a[K+1:0];
      r_pHi1  <= w_pHi1;
      r_tag1  <= in_tag;
      r_v2    <= r_v1;
      r_r2    <= w_r2;
      r_tag2  <= r_tag1;
      r_v3    <= r_v2;
      r_dout3 <= w_dout3;
      r_tag3  <= r_tag2;
    end
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Self-checking bench for barrett_reduce_pipe: directed vectors, stall/reset sequences and
// randomized traffic on three parameterisations, all scored against a plain a % Q model.
module tb_barrett_reduce_pipe;

   localparam int     Q   = 3433;
   localparam int     K   = 12;
   localparam int     TW  = 4;
   localparam longint QSQ = longint'(Q) * longint'(Q);

   typedef struct {
      logic [23:0] a;
      logic [3:0]  tag;
      logic [11:0] r;
   } tvecT;

   typedef struct {
      longint      a;
      logic [3:0]  tag;
      int          acc;
   } opT;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [23:0] dinA;
   logic [3:0]  inTag;
   logic        outValid;
   logic        outReady;
   logic [11:0] doutR;
   logic [3:0]  outTag;
`ifdef BARRETT_RANGE_CHK_EN
   logic        err;
   logic        bErr;
   logic        cErr;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   latChk = 1'b0;
   bit   readyRandom = 1'b0;
   opT   mainQ[$];
   tvecT vec[11];

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Cycle counter used to measure input-to-output latency of each operand
   always @(posedge clk) cyc <= cyc + 1;

   barrett_reduce_pipe #(.Q(Q), .K(K), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .din_a(dinA),
      .in_tag(inTag), .out_valid(outValid), .out_ready(outReady), .dout_r(doutR),
      .out_tag(outTag)
`ifdef BARRETT_RANGE_CHK_EN
      , .err(err)
`endif
   );

   function automatic longint refMod(input longint a, input longint m);
      return a % m;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // Present one operand (caller sits just after a rising edge) and hold it until accepted
   task automatic applyStimulus(input logic [23:0] a, input logic [3:0] t);
      int w;
      w = 0;
      dinA = a;
      inTag = t;
      inValid = 1'b1;
      @(negedge clk);
      while (!inReady && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!inReady) checkOutput("acceptTimeout", 0, 1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   task automatic idle(input int n);
      inValid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitDrain(input string name);
      int w;
      w = 0;
      while (mainQ.size() != 0 && w < 300) begin
         @(posedge clk);
         w++;
      end
      #1;
      checkOutput(name, mainQ.size(), 0);
   endtask

   // Random output backpressure, only active while readyRandom is set
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (readyRandom) outReady = ($urandom_range(0, 3) != 0);
      end
   end

   // Scoreboard for the default DUT: records accepts, checks every output beat in order,
   // checks stability while stalled and optionally the exact 3-cycle latency
   logic        prevHold = 1'b0;
   logic [11:0] prevR;
   logic [3:0]  prevTag;
   always @(negedge clk) begin
      opT e;
      longint expR;
      logic   expErr;
      if (rst) begin
         mainQ.delete();
         prevHold = 1'b0;
      end else begin
         if (prevHold) begin
            checkOutput("holdValid", outValid, 1);
            checkOutput("holdData", doutR, prevR);
            checkOutput("holdTag", outTag, prevTag);
         end
         if (outValid && outReady) begin
            if (mainQ.size() == 0) begin
               checkOutput("spuriousBeat", 1, 0);
            end else begin
               e = mainQ.pop_front();
               expErr = (e.a >= QSQ);
               expR = expErr ? 0 : refMod(e.a, Q);
               checkOutput("result", doutR, expR);
               checkOutput("tag", outTag, e.tag);
`ifdef BARRETT_RANGE_CHK_EN
               checkOutput("err", err, expErr);
`endif
               if (latChk) checkOutput("latency", cyc - e.acc, 3);
            end
         end
         prevHold = outValid && !outReady;
         prevR = doutR;
         prevTag = outTag;
         if (inValid && inReady) begin
            e.a = dinA;
            e.tag = inTag;
            e.acc = cyc;
            mainQ.push_back(e);
         end
      end
   end

   // Second instance: Q = 3329, K = 12, random valid/ready with its own scoreboard
   logic        bRst, bInValid, bInReady, bOutValid, bOutReady, bHit;
   logic [23:0] bDin;
   logic [3:0]  bTag, bOutTag;
   logic [11:0] bDout;
   bit          bDone = 1'b0;
   longint      bAq[$];
   logic [3:0]  bTq[$];

   barrett_reduce_pipe #(.Q(3329), .K(12), .TAG_W(4)) dutB (
      .clk(clk), .rst(bRst), .in_valid(bInValid), .in_ready(bInReady), .din_a(bDin),
      .in_tag(bTag), .out_valid(bOutValid), .out_ready(bOutReady), .dout_r(bDout),
      .out_tag(bOutTag)
`ifdef BARRETT_RANGE_CHK_EN
      , .err(bErr)
`endif
   );

   // Driver for the Q = 3329 instance: random gaps and backpressure, operand held until taken
   initial begin
      int sent;
      int cnt;
      sent = 0;
      cnt = 0;
      bRst = 1'b1; bInValid = 1'b0; bDin = '0; bTag = '0; bOutReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 bRst = 1'b0;
      while (sent < 300 && cnt < 4000) begin
         if (!bInValid && $urandom_range(0, 3) != 0) begin
            bInValid = 1'b1;
            bDin = 24'($urandom_range(0, 3329 * 3329 - 1));
            bTag = 4'($urandom_range(0, 15));
         end
         bOutReady = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         bHit = bInValid && bInReady;
         @(posedge clk);
         #1;
         if (bHit) begin
            sent++;
            bInValid = 1'b0;
         end
         cnt++;
      end
      bInValid = 1'b0;
      bOutReady = 1'b1;
      cnt = 0;
      while (bAq.size() != 0 && cnt < 100) begin
         @(posedge clk);
         cnt++;
      end
      #1 checkOutput("bDrain", bAq.size(), 0);
      bDone = 1'b1;
   end

   // Scoreboard for the Q = 3329 instance
   always @(negedge clk) begin
      longint a;
      logic [3:0] t;
      if (bRst) begin
         bAq.delete();
         bTq.delete();
      end else begin
         if (bOutValid && bOutReady) begin
            if (bAq.size() == 0) begin
               checkOutput("bSpurious", 1, 0);
            end else begin
               a = bAq.pop_front();
               t = bTq.pop_front();
               checkOutput("bResult", bDout, refMod(a, 3329));
               checkOutput("bTag", bOutTag, t);
            end
         end
         if (bInValid && bInReady) begin
            bAq.push_back(longint'(bDin));
            bTq.push_back(bTag);
         end
      end
   end

   // Third instance: Q = 7681, K = 13
   logic        cRst, cInValid, cInReady, cOutValid, cOutReady, cHit;
   logic [25:0] cDin;
   logic [3:0]  cTag, cOutTag;
   logic [12:0] cDout;
   bit          cDone = 1'b0;
   longint      cAq[$];
   logic [3:0]  cTq[$];

   barrett_reduce_pipe #(.Q(7681), .K(13), .TAG_W(4)) dutC (
      .clk(clk), .rst(cRst), .in_valid(cInValid), .in_ready(cInReady), .din_a(cDin),
      .in_tag(cTag), .out_valid(cOutValid), .out_ready(cOutReady), .dout_r(cDout),
      .out_tag(cOutTag)
`ifdef BARRETT_RANGE_CHK_EN
      , .err(cErr)
`endif
   );

   // Driver for the Q = 7681 instance
   initial begin
      int sent;
      int cnt;
      sent = 0;
      cnt = 0;
      cRst = 1'b1; cInValid = 1'b0; cDin = '0; cTag = '0; cOutReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 cRst = 1'b0;
      while (sent < 300 && cnt < 4000) begin
         if (!cInValid && $urandom_range(0, 3) != 0) begin
            cInValid = 1'b1;
            cDin = 26'($urandom_range(0, 7681 * 7681 - 1));
            cTag = 4'($urandom_range(0, 15));
         end
         cOutReady = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         cHit = cInValid && cInReady;
         @(posedge clk);
         #1;
         if (cHit) begin
            sent++;
            cInValid = 1'b0;
         end
         cnt++;
      end
      cInValid = 1'b0;
      cOutReady = 1'b1;
      cnt = 0;
      while (cAq.size() != 0 && cnt < 100) begin
         @(posedge clk);
         cnt++;
      end
      #1 checkOutput("cDrain", cAq.size(), 0);
      cDone = 1'b1;
   end

   // Scoreboard for the Q = 7681 instance
   always @(negedge clk) begin
      longint a;
      logic [3:0] t;
      if (cRst) begin
         cAq.delete();
         cTq.delete();
      end else begin
         if (cOutValid && cOutReady) begin
            if (cAq.size() == 0) begin
               checkOutput("cSpurious", 1, 0);
            end else begin
               a = cAq.pop_front();
               t = cTq.pop_front();
               checkOutput("cResult", cDout, refMod(a, 7681));
               checkOutput("cTag", cOutTag, t);
            end
         end
         if (cInValid && cInReady) begin
            cAq.push_back(longint'(cDin));
            cTq.push_back(cTag);
         end
      end
   end

   // Main test sequence on the default instance
   initial begin
      logic [23:0] randA;
      int w;

      vec[0]  = '{24'd0,        4'd0, 12'd0};
      vec[1]  = '{24'd3432,     4'd1, 12'd3432};
      vec[2]  = '{24'd3433,     4'd2, 12'd0};
      vec[3]  = '{24'd11778624, 4'd3, 12'd1};
      vec[4]  = '{24'd6866,     4'd0, 12'd0};
      vec[5]  = '{24'd10299,    4'd1, 12'd0};
      vec[6]  = '{24'd4887,     4'd2, 12'd1454};
      vec[7]  = '{24'd100000,   4'd3, 12'd443};
      vec[8]  = '{24'd11785488, 4'd4, 12'd3432};
      vec[9]  = '{24'd6865,     4'd5, 12'd3432};
      vec[10] = '{24'd5000000,  4'd6, 12'd1552};

      rst = 1'b1; inValid = 1'b0; dinA = '0; inTag = '0; outReady = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      checkOutput("resetOutValid", outValid, 0);
      checkOutput("resetDout", doutR, 0);
      checkOutput("resetTag", outTag, 0);
      checkOutput("resetInReady", inReady, 1);
`ifdef BARRETT_RANGE_CHK_EN
      checkOutput("resetErr", err, 0);
`endif

      // Back-to-back table vectors, each output expected exactly three cycles later
      @(posedge clk);
      #1;
      latChk = 1'b1;
      for (int k = 0; k < 14; k++) begin
         if (k < 11) begin
            dinA = vec[k].a;
            inTag = vec[k].tag;
            inValid = 1'b1;
         end else begin
            inValid = 1'b0;
         end
         @(negedge clk);
         checkOutput("tblInReady", inReady, 1);
         if (k < 3) begin
            checkOutput("tblEarly", outValid, 0);
         end else begin
            checkOutput("tblValid", outValid, 1);
            checkOutput("tblResult", doutR, vec[k-3].r);
            checkOutput("tblTag", outTag, vec[k-3].tag);
         end
         @(posedge clk);
         #1;
      end
      waitDrain("tblDrain");

      // Continuous input with a 5-cycle output stall once results start flowing
      latChk = 1'b0;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 12; i++) applyStimulus(24'(12345 + i * 977), 4'(i));
            inValid = 1'b0;
         end
         begin
            int sw;
            sw = 0;
            @(negedge clk);
            while (!outValid && sw < 50) begin
               @(negedge clk);
               sw++;
            end
            checkOutput("stallStart", outValid, 1);
            @(posedge clk);
            #1 outReady = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               checkOutput("stallInReady", inReady, 0);
               checkOutput("stallOutValid", outValid, 1);
            end
            @(posedge clk);
            #1 outReady = 1'b1;
         end
      join
      waitDrain("stallDrain");

      // Reset pulse while operands are in flight: nothing may emerge afterwards
      latChk = 1'b1;
      @(posedge clk);
      #1;
      dinA = 24'd1000; inTag = 4'd7; inValid = 1'b1;
      @(posedge clk);
      #1;
      dinA = 24'd2000; inTag = 4'd8;
      @(posedge clk);
      #1;
      dinA = 24'd3000; inTag = 4'd9; rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; inValid = 1'b0;
      @(negedge clk);
      checkOutput("rstInReady", inReady, 1);
      for (int s = 0; s < 5; s++) begin
         checkOutput("rstFlush", outValid, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      dinA = 24'd4000; inTag = 4'd10; inValid = 1'b1;
      @(negedge clk);
      checkOutput("rstNextAccept", inReady, 1);
      @(posedge clk);
      #1 inValid = 1'b0;
      @(negedge clk);
      checkOutput("rstLat1", outValid, 0);
      @(negedge clk);
      checkOutput("rstLat2", outValid, 0);
      @(negedge clk);
      checkOutput("rstLat3", outValid, 1);
      checkOutput("rstResult", doutR, 567);
      checkOutput("rstTag", outTag, 10);
      @(posedge clk);
      #1;
      waitDrain("rstDrain");

`ifdef BARRETT_RANGE_CHK_EN
      // Boundary of the legal operand range
      applyStimulus(24'(QSQ), 4'd11);
      applyStimulus(24'(QSQ - 1), 4'd12);
      idle(4);
      waitDrain("rangeDrain");
`endif

      // Random operands, random gaps and random backpressure
      latChk = 1'b0;
      readyRandom = 1'b1;
      for (int i = 0; i < 250; i++) begin
         idle($urandom_range(0, 2));
         randA = 24'($urandom_range(0, int'(QSQ - 1)));
`ifdef BARRETT_RANGE_CHK_EN
         if ($urandom_range(0, 9) == 0) randA = 24'($urandom_range(int'(QSQ), 24'hFFFFFF));
`endif
         applyStimulus(randA, 4'($urandom_range(0, 15)));
      end
      readyRandom = 1'b0;
      @(posedge clk);
      #1 outReady = 1'b1;
      waitDrain("randDrain");

      w = 0;
      while (!(bDone && cDone) && w < 20000) begin
         @(posedge clk);
         w++;
      end
      checkOutput("auxDone", (bDone && cDone), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
